program_counter: RTL and testbench

//  - Holds the 32-bit fetch address of the single-cycle RISC-V (RV32I) core.
//  - Each enabled cycle it loads the next PC from the control-unit op (cuOP), ALU flags, rs1 and the immediate.
//  - Feeds the instruction-memory address bus. Register-file link writes (PC+4) are computed elsewhere unless PC_LINK_EN is defined.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/pc_next_logic.sv | 34 +++
 rtl/program_counter.sv | 49 ++++
 tb/tb_program_counter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core package: decoded control-unit op encoding, PC step constant and
// the branch-condition helper used by the fetch-address logic.
package cpu_pkg;

    // Decoded op from the control unit; encoding order is fixed (starts at 0)
    typedef enum logic [5:0] {
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
        CU_SB, CU_SH, CU_SW,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU, CU_XORI, CU_ORI, CU_ANDI,
        CU_SLLI, CU_SRLI, CU_SRAI,
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA,
        CU_OR, CU_AND,
        CU_ERROR
    } cuOPType;

    // Sequential fetch increment (one 32-bit instruction)
    localparam logic [31:0] PC_STEP = 32'd4;

    // Branch decision from ALU flags. The ALU already did the signed or
    // unsigned compare, so signed/unsigned variants share one condition.
    // Non-branch ops report "not taken".
    function automatic logic branch_taken(input cuOPType op, input logic neg,
                                          input logic zero);
        logic taken;
        taken = 1'b0;
        case (op)
            CU_BEQ:           taken = zero;
            CU_BNE:           taken = !zero;
            CU_BLT, CU_BLTU:  taken = neg && !zero;
            CU_BGE, CU_BGEU:  taken = !neg || zero;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-fetch-address selection for the single-cycle core.
// Picks among sequential, PC-relative (JAL / taken branch) and register-based
// (JALR, bit 0 forced low) targets. All adds wrap modulo 2^32.
import cpu_pkg::*;

module pc_next_logic (
    input  cuOPType     cuOP,
    input  logic [31:0] pc,
    input  logic [31:0] rs1Read,
    input  logic [31:0] signExtend,
    input  logic        ALUneg,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic [31:0] seq_addr;
    logic [31:0] rel_addr;
    logic [31:0] reg_addr;

    assign seq_addr = pc + PC_STEP;
    assign rel_addr = pc + signExtend;
    assign reg_addr = rs1Read + signExtend;

    // Select the next address; unknown/illegal ops just fall through to PC+4
    always_comb begin
        next_pc = seq_addr;
        case (cuOP)
            CU_JAL:  next_pc = rel_addr;
            CU_JALR: next_pc = {reg_addr[31:1], 1'b0};
            default: next_pc = branch_taken(cuOP, ALUneg, Zero) ? rel_addr : seq_addr;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// Program counter of the single-cycle RV32I core: holds the fetch address and
// loads the next address from pc_next_logic on each cycle with iready high.
// Optional feature macro PC_LINK_EN adds the linkAddr (PC+4) output.
import cpu_pkg::*;

module program_counter #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nRST,
    input  cuOPType     cuOP,
    input  logic [31:0] rs1Read,
    input  logic [31:0] signExtend,
    input  logic        ALUneg,
    input  logic        Zero,
    input  logic        iready,
    output logic [31:0] PCaddr
`ifdef PC_LINK_EN
    ,
    output logic [31:0] linkAddr
`endif
);

    logic [31:0] next_pc;

    pc_next_logic u_next (
        .cuOP       (cuOP),
        .pc         (PCaddr),
        .rs1Read    (rs1Read),
        .signExtend (signExtend),
        .ALUneg     (ALUneg),
        .Zero       (Zero),
        .next_pc    (next_pc)
    );

    // PC register: async reset wins; otherwise advance only when fetch is ready
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            PCaddr <= RESET_ADDR;
        else if (iready)
            PCaddr <= next_pc;
    end

`ifdef PC_LINK_EN
    // Return address for JAL/JALR; tracks RESET_ADDR+4 during reset for free
    assign linkAddr = PCaddr + PC_STEP;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: expected PC values are pushed to a
// scoreboard when stimulus is driven and popped when the register updates.
`timescale 1ns/1ps
import cpu_pkg::*;

module tb_program_counter;

    logic        clk = 1'b0;
    logic        nRST;
    cuOPType     cuOP;
    logic [31:0] rs1Read;
    logic [31:0] signExtend;
    logic        ALUneg;
    logic        Zero;
    logic        iready;
    logic [31:0] PCaddr;
`ifdef PC_LINK_EN
    logic [31:0] linkAddr;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_v;

    program_counter dut (
        .clk        (clk),
        .nRST       (nRST),
        .cuOP       (cuOP),
        .rs1Read    (rs1Read),
        .signExtend (signExtend),
        .ALUneg     (ALUneg),
        .Zero       (Zero),
        .iready     (iready),
        .PCaddr     (PCaddr)
`ifdef PC_LINK_EN
        ,
        .linkAddr   (linkAddr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got pc %h want summary", PCaddr);
        $fatal(1, "watchdog");
    end

    // Drive a full input set at the falling edge
    task automatic drive(input cuOPType op, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic neg, input logic z, input logic rdy);
        @(negedge clk);
        cuOP = op; rs1Read = rs1; signExtend = imm; ALUneg = neg; Zero = z; iready = rdy;
    endtask

    // Let one rising edge happen, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a known PC through JALR with zero offset (a must be even)
    task automatic set_pc(input logic [31:0] a);
        drive(CU_JALR, a, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        cuOP = CU_ADD; rs1Read = '0; signExtend = '0; ALUneg = 0; Zero = 0; iready = 1;
        #12;
        total++;
        if (PCaddr !== 32'h0) begin
            bad++; $display("FAIL reset_hold: got %h want %h", PCaddr, 32'h0);
        end
        drive(CU_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nRST = 1'b1;
        sb.push_back(32'h4);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL reset_first_edge: got %h want %h", PCaddr, exp_v);
        end
        sb.push_back(32'h8);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL reset_second_edge: got %h want %h", PCaddr, exp_v);
        end
        // Mid-cycle async reset, no clock edge in between
        #2 nRST = 1'b0;
        #1;
        total++;
        if (PCaddr !== 32'h0) begin
            bad++; $display("FAIL reset_async: got %h want %h", PCaddr, 32'h0);
        end
        // Reset wins over iready on an edge
        cuOP = CU_JAL; signExtend = 32'h40;
        tick();
        total++;
        if (PCaddr !== 32'h0) begin
            bad++; $display("FAIL reset_wins: got %h want %h", PCaddr, 32'h0);
        end
        drive(CU_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nRST = 1'b1;
        sb.push_back(32'h4);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL reset_rerelease: got %h want %h", PCaddr, exp_v);
        end
    endtask

    task automatic test_jal();
        set_pc(32'h100);
        drive(CU_JAL, 32'hDEAD_BEEF, 32'h20, 1'b0, 1'b0, 1'b1);
        sb.push_back(32'h120);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL jal_fwd: got %h want %h", PCaddr, exp_v);
        end
        drive(CU_JAL, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1);
        sb.push_back(32'h110);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL jal_neg: got %h want %h", PCaddr, exp_v);
        end
    endtask

    task automatic test_jalr();
        drive(CU_JALR, 32'h1001, 32'h4, 1'b0, 1'b0, 1'b1);
        sb.push_back(32'h1004);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL jalr_bit0: got %h want %h", PCaddr, exp_v);
        end
        drive(CU_JALR, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b1);
        sb.push_back(32'h0);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL jalr_wrap: got %h want %h", PCaddr, exp_v);
        end
    endtask

    typedef struct {
        cuOPType     op;
        logic        neg;
        logic        z;
        logic [31:0] want;
    } br_case_t;

    task automatic test_branch();
        br_case_t tbl[11];
        tbl[0]  = '{CU_BEQ,  1'b0, 1'b1, 32'h50};
        tbl[1]  = '{CU_BEQ,  1'b0, 1'b0, 32'h44};
        tbl[2]  = '{CU_BNE,  1'b0, 1'b0, 32'h50};
        tbl[3]  = '{CU_BNE,  1'b0, 1'b1, 32'h44};
        tbl[4]  = '{CU_BLT,  1'b1, 1'b0, 32'h50};
        tbl[5]  = '{CU_BLT,  1'b1, 1'b1, 32'h44};
        tbl[6]  = '{CU_BGE,  1'b0, 1'b0, 32'h50};
        tbl[7]  = '{CU_BGE,  1'b1, 1'b1, 32'h50};
        tbl[8]  = '{CU_BLTU, 1'b1, 1'b0, 32'h50};
        tbl[9]  = '{CU_BLTU, 1'b0, 1'b0, 32'h44};
        tbl[10] = '{CU_BGEU, 1'b1, 1'b0, 32'h44};
        for (int i = 0; i < 11; i++) begin
            set_pc(32'h40);
            drive(tbl[i].op, 32'h0, 32'h10, tbl[i].neg, tbl[i].z, 1'b1);
            sb.push_back(tbl[i].want);
            tick();
            exp_v = sb.pop_front(); total++;
            if (PCaddr !== exp_v) begin
                bad++;
                $display("FAIL branch_%s_n%0d_z%0d: got %h want %h",
                         tbl[i].op.name(), tbl[i].neg, tbl[i].z, PCaddr, exp_v);
            end
        end
        // CU_ERROR falls back to sequential fetch
        set_pc(32'h40);
        drive(CU_ERROR, 32'h0, 32'h10, 1'b1, 1'b1, 1'b1);
        sb.push_back(32'h44);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL error_op: got %h want %h", PCaddr, exp_v);
        end
    endtask

    task automatic test_stall();
        set_pc(32'h300);
        drive(CU_JAL, 32'h0, 32'h30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(32'h300);
            tick();
            exp_v = sb.pop_front(); total++;
            if (PCaddr !== exp_v) begin
                bad++; $display("FAIL stall_hold_%0d: got %h want %h", i, PCaddr, exp_v);
            end
        end
        drive(CU_JAL, 32'h0, 32'h30, 1'b0, 1'b0, 1'b1);
        sb.push_back(32'h330);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL stall_release: got %h want %h", PCaddr, exp_v);
        end
        drive(CU_JAL, 32'h0, 32'h30, 1'b0, 1'b0, 1'b0);
        sb.push_back(32'h330);
        tick();
        exp_v = sb.pop_front(); total++;
        if (PCaddr !== exp_v) begin
            bad++; $display("FAIL stall_once: got %h want %h", PCaddr, exp_v);
        end
    endtask

    // Reference next-PC written straight from the op table
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input cuOPType op,
                                             input logic [31:0] rs1, input logic [31:0] imm,
                                             input logic neg, input logic z);
        logic [31:0] sum;
        if (op == CU_JAL)  return pc + imm;
        if (op == CU_JALR) begin
            sum = rs1 + imm;
            return sum & 32'hFFFF_FFFE;
        end
        if ((op == CU_BEQ && z) || (op == CU_BNE && !z) ||
            ((op == CU_BLT || op == CU_BLTU) && neg && !z) ||
            ((op == CU_BGE || op == CU_BGEU) && (!neg || z)))
            return pc + imm;
        return pc + 32'd4;
    endfunction

    task automatic test_back_to_back();
        logic [31:0] mpc;
        cuOPType     op;
        logic [31:0] rs1, imm;
        logic        neg, z, rdy;
        set_pc(32'h8000);
        mpc = 32'h8000;
        for (int i = 0; i < 40; i++) begin
            op  = cuOPType'($urandom_range(0, 38));
            rs1 = $urandom();
            imm = $urandom();
            neg = 1'($urandom_range(0, 1));
            z   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            drive(op, rs1, imm, neg, z, rdy);
            if (rdy) mpc = ref_next(mpc, op, rs1, imm, neg, z);
            sb.push_back(mpc);
            tick();
            exp_v = sb.pop_front(); total++;
            if (PCaddr !== exp_v) begin
                bad++; $display("FAIL b2b_%0d_%s: got %h want %h", i, op.name(), PCaddr, exp_v);
            end
        end
    endtask

`ifdef PC_LINK_EN
    task automatic test_link();
        set_pc(32'h200);
        total++;
        if (linkAddr !== 32'h204) begin
            bad++; $display("FAIL link_run: got %h want %h", linkAddr, 32'h204);
        end
        #2 nRST = 1'b0;
        #1;
        total++;
        if (linkAddr !== 32'h4) begin
            bad++; $display("FAIL link_reset: got %h want %h", linkAddr, 32'h4);
        end
        drive(CU_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nRST = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_jal();
        test_jalr();
        test_branch();
        test_stall();
        test_back_to_back();
`ifdef PC_LINK_EN
        test_link();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
